fp_unit_dispatcher: RTL and testbench
=====================================

// Module: fp_unit_dispatcher
// PURPOSE
//  Initiator side of the shared-APU FP unit protocol (En/OpA/Rnd/Tag out; Valid/Tag/Res/Status back).
//  Accepts core requests on a req/gnt handshake and allocates a slot tag per request.
//  Drives one pipelined FP unit (sqrt, div, ...) and collects tagged results into a slot buffer.
//  Returns results to the core in issue order on a valid/ready interface.
// PARAMETERS
//  FP_WIDTH    32  operand/result width
//  RND_WIDTH   3   rounding-mode width
//  STAT_WIDTH  8   unit status-flag width
//  ID_WIDTH    4   core request ID width, echoed on the response
//  NUM_SLOTS   4   max outstanding ops; power of 2, >=2
//  TAG_WIDTH   $clog2(NUM_SLOTS)  unit tag width; derived, not overridable
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           async reset, active high
//  Req_i         in   1           core request
//  OpA_i         in   FP_WIDTH    operand
//  Rnd_i         in   RND_WIDTH   rounding mode
//  Id_i          in   ID_WIDTH    core request ID
//  Gnt_o         out  1           request accepted this cycle
//  RespValid_o   out  1           response available
//  RespReady_i   in   1           core accepts response
//  RespRes_o     out  FP_WIDTH    result
//  RespStatus_o  out  STAT_WIDTH  status flags
//  RespId_o      out  ID_WIDTH    ID of the originating request
//  UnitEn_o      out  1           issue pulse to FP unit
//  UnitOpA_o     out  FP_WIDTH    operand to unit; 0 when UnitEn_o=0
//  UnitRnd_o     out  RND_WIDTH   rounding mode to unit
//  UnitTag_o     out  TAG_WIDTH   slot tag to unit
//  UnitReady_i   in   1           unit can accept an op
//  UnitValid_i   in   1           unit result valid
//  UnitTag_i     in   TAG_WIDTH   tag of returned result
//  UnitRes_i     in   FP_WIDTH    unit result
//  UnitStatus_i  in   STAT_WIDTH  unit status
//  Busy_o        out  1           at least one slot occupied
//  TagErr_o      out  1           sticky tag error; tied 0 without macro
// BEHAVIOUR
//  Reset: every output 0; head/tail pointers, count and all slot busy/done bits cleared.
//  Grant: Gnt_o = Req_i & UnitReady_i & (count < NUM_SLOTS); combinational, no full bypass.
//  Issue on Req_i & Gnt_o:
//   - slot[head] gets busy=1, done=0, id=Id_i; head increments mod NUM_SLOTS.
//   - Next cycle: UnitEn_o=1 for one cycle, UnitOpA_o=OpA_i, UnitRnd_o=Rnd_i, UnitTag_o=old head.
//   - Latency req->UnitEn_o is 1 cycle. Back-to-back issue gives a continuous UnitEn_o stream.
//  Result on UnitValid_i: slot[UnitTag_i] gets done=1, res, status. Any return order is allowed.
//  Response:
//   - RespValid_o = busy[tail] & done[tail]; RespRes/Status/Id_o come from slot[tail] (registered).
//   - RespValid_o rises 1 cycle after the unit returns the tail slot's result; there is no bypass.
//   - On RespValid_o & RespReady_i: busy[tail] cleared, tail increments mod NUM_SLOTS.
//   - The response is held stable while RespReady_i=0.
//  Count: +1 on issue, -1 on retire, unchanged when both happen in the same cycle.
//   - Full (count==NUM_SLOTS): Gnt_o=0, even if a retire occurs in the same cycle.
//  Write priority: a result write and an allocation never target the same slot.
//   - The allocated slot is free by construction, and a valid unit never returns a free tag.
//  Busy_o = (count != 0).
//  Reset mid-operation: in-flight ops are discarded.
//   - A late UnitValid_i to a free slot only sets done; RespValid_o needs busy=1.
//   - Allocation clears done, so a late result never produces a response.
//  No backpressure on the unit side: NUM_SLOTS credits bound in-flight ops, so results never drop.
// CONFIGURATION
//  FP_DISPATCH_TAGCHK_EN defined:
//   - A UnitValid_i whose tag slot is not busy, or is already done, is dropped.
//   - TagErr_o is set and stays 1 until reset.
//  Undefined: results are written unconditionally; TagErr_o is constant 0.
// TESTING
//  1 Req OpA=0x40800000 Id=5 -> Gnt same cycle; next cycle UnitEn=1 Tag=0;
//    model returns 0x40000000 after 2 cycles -> RespValid 1 cycle later, Id=5, Res=0x40000000.
//  2 RespReady=0, 5 back-to-back Reqs -> first 4 granted (Tags 0..3), 5th Gnt=0 until 1 retire.
//  3 Issue Id 1,2; unit returns Tag1 then Tag0 -> responses in order Id1 then Id2.
//  4 RespReady=0 for 10 cycles with 3 results done -> Resp outputs stable;
//    then 3 consecutive handshakes, then Busy_o=0.
//  5 count=2 with issue and retire in one cycle -> count stays 2;
//    9 ops total -> tags wrap 3->0, order preserved.
//  6 Macro on: UnitValid with Tag=2 while slot2 is free -> TagErr_o=1 sticky, no response.
//    Macro off: TagErr_o=0.

Source files
------------

// File: rtl/fp_unit_dispatcher.sv
// fp_unit_dispatcher: issues tagged core requests to one pipelined FP unit and returns the
// results to the core in issue order. Define FP_DISPATCH_TAGCHK_EN to drop and flag bad result tags.
module fp_unit_dispatcher #(
  parameter int FP_WIDTH   = 32,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_SLOTS  = 4,
  localparam int TAG_WIDTH = $clog2(NUM_SLOTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Req_i,
  input  logic [FP_WIDTH-1:0]   OpA_i,
  input  logic [RND_WIDTH-1:0]  Rnd_i,
  input  logic [ID_WIDTH-1:0]   Id_i,
  output logic                  Gnt_o,
  output logic                  RespValid_o,
  input  logic                  RespReady_i,
  output logic [FP_WIDTH-1:0]   RespRes_o,
  output logic [STAT_WIDTH-1:0] RespStatus_o,
  output logic [ID_WIDTH-1:0]   RespId_o,
  output logic                  UnitEn_o,
  output logic [FP_WIDTH-1:0]   UnitOpA_o,
  output logic [RND_WIDTH-1:0]  UnitRnd_o,
  output logic [TAG_WIDTH-1:0]  UnitTag_o,
  input  logic                  UnitReady_i,
  input  logic                  UnitValid_i,
  input  logic [TAG_WIDTH-1:0]  UnitTag_i,
  input  logic [FP_WIDTH-1:0]   UnitRes_i,
  input  logic [STAT_WIDTH-1:0] UnitStatus_i,
  output logic                  Busy_o,
  output logic                  TagErr_o
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0]     FULL    = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);

  logic [TAG_WIDTH-1:0]  head, tail;
  logic [CNT_W-1:0]      count;
  logic [NUM_SLOTS-1:0]  busy, done;
  logic [ID_WIDTH-1:0]   id_mem   [NUM_SLOTS];
  logic [FP_WIDTH-1:0]   res_mem  [NUM_SLOTS];
  logic [STAT_WIDTH-1:0] stat_mem [NUM_SLOTS];
  logic                  issue, retire, res_wr, resp_valid;

  assign Gnt_o      = Req_i & UnitReady_i & (count < FULL);
  assign issue      = Req_i & Gnt_o;
  assign resp_valid = busy[tail] & done[tail];
  assign retire     = resp_valid & RespReady_i;
  assign Busy_o     = (count != '0);

  // Response fields are forced to zero whenever no response is presented.
  assign RespValid_o  = resp_valid;
  assign RespRes_o    = resp_valid ? res_mem[tail]  : '0;
  assign RespStatus_o = resp_valid ? stat_mem[tail] : '0;
  assign RespId_o     = resp_valid ? id_mem[tail]   : '0;

`ifdef FP_DISPATCH_TAGCHK_EN
  assign res_wr = UnitValid_i & busy[UnitTag_i] & ~done[UnitTag_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      TagErr_o <= 1'b0;
    else if (UnitValid_i && !res_wr)
      TagErr_o <= 1'b1;
  end
`else
  assign res_wr   = UnitValid_i;
  assign TagErr_o = 1'b0;
`endif

  // Stage p0 -> p1: slot bookkeeping and the registered issue to the unit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      done      <= '0;
      UnitEn_o  <= 1'b0;
      UnitOpA_o <= '0;
      UnitRnd_o <= '0;
      UnitTag_o <= '0;
    end else begin
      UnitEn_o  <= issue;
      UnitOpA_o <= issue ? OpA_i : '0;
      UnitRnd_o <= issue ? Rnd_i : '0;
      UnitTag_o <= issue ? head  : '0;
      if (res_wr)
        done[UnitTag_i] <= 1'b1;
      // Allocation wins over a stale result aimed at the same (free) slot.
      if (issue) begin
        busy[head] <= 1'b1;
        done[head] <= 1'b0;
        head       <= head + TAG_ONE;
      end
      if (retire) begin
        busy[tail] <= 1'b0;
        tail       <= tail + TAG_ONE;
      end
      case ({issue, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Slot payload storage; validity is carried by busy/done, so no reset here.
  always_ff @(posedge clk_i) begin
    if (issue)
      id_mem[head] <= Id_i;
    if (res_wr) begin
      res_mem[UnitTag_i]  <= UnitRes_i;
      stat_mem[UnitTag_i] <= UnitStatus_i;
    end
  end

endmodule

// File: tb/tb_fp_unit_dispatcher.sv
// Randomized bench for fp_unit_dispatcher: an out-of-order FP unit model plus an
// issue-order scoreboard predict every output each cycle.
module tb_fp_unit_dispatcher;
  localparam int FP_WIDTH = 32, RND_WIDTH = 3, STAT_WIDTH = 8, ID_WIDTH = 4;
  localparam int NUM_SLOTS = 4, TAG_WIDTH = 2;

  logic clk = 1'b0;
  logic rst;
  logic Req_i, Gnt_o, RespValid_o, RespReady_i, UnitEn_o, UnitReady_i, UnitValid_i;
  logic Busy_o, TagErr_o;
  logic [FP_WIDTH-1:0]   OpA_i, RespRes_o, UnitOpA_o, UnitRes_i;
  logic [RND_WIDTH-1:0]  Rnd_i, UnitRnd_o;
  logic [ID_WIDTH-1:0]   Id_i, RespId_o;
  logic [STAT_WIDTH-1:0] RespStatus_o, UnitStatus_i;
  logic [TAG_WIDTH-1:0]  UnitTag_o, UnitTag_i;

  always #5 clk = ~clk;

  fp_unit_dispatcher dut (
    .clk_i(clk), .rst_i(rst), .Req_i(Req_i), .OpA_i(OpA_i), .Rnd_i(Rnd_i), .Id_i(Id_i),
    .Gnt_o(Gnt_o), .RespValid_o(RespValid_o), .RespReady_i(RespReady_i),
    .RespRes_o(RespRes_o), .RespStatus_o(RespStatus_o), .RespId_o(RespId_o),
    .UnitEn_o(UnitEn_o), .UnitOpA_o(UnitOpA_o), .UnitRnd_o(UnitRnd_o), .UnitTag_o(UnitTag_o),
    .UnitReady_i(UnitReady_i), .UnitValid_i(UnitValid_i), .UnitTag_i(UnitTag_i),
    .UnitRes_i(UnitRes_i), .UnitStatus_i(UnitStatus_i), .Busy_o(Busy_o), .TagErr_o(TagErr_o)
  );

  typedef struct {
    logic [ID_WIDTH-1:0]   id;
    logic [FP_WIDTH-1:0]   res;
    logic [STAT_WIDTH-1:0] st;
    int                    tag;
    bit                    returned;
  } op_t;

  typedef struct {
    int                    tag;
    logic [FP_WIDTH-1:0]   res;
    logic [STAT_WIDTH-1:0] st;
    int                    age;
  } unit_op_t;

  op_t      exp_q[$];
  unit_op_t pend[$];
  int checks = 0, errors = 0;
  int issued = 0;
  bit exp_en = 0, exp_tagerr = 0;
  logic [FP_WIDTH-1:0]  iss_opa;
  logic [RND_WIDTH-1:0] iss_rnd;
  int iss_tag;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FP_WIDTH-1:0] fres(input logic [FP_WIDTH-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] fstat(input logic [FP_WIDTH-1:0] a);
    return a[7:0] ^ a[31:24];
  endfunction

  // One clock: check all outputs against the model, drive new inputs, advance the model.
  task automatic cycle(input int req_pct, input int rdy_pct, input int ret_pct);
    bit g, r, ev;
    int ri;
    @(negedge clk);
    check_eq("unit_en", UnitEn_o, exp_en);
    if (exp_en) begin
      check_eq("unit_opa", UnitOpA_o, iss_opa);
      check_eq("unit_rnd", UnitRnd_o, iss_rnd);
      check_eq("unit_tag", UnitTag_o, iss_tag);
      pend.push_back('{iss_tag, fres(iss_opa), fstat(iss_opa), 0});
    end else
      check_eq("unit_opa_idle", UnitOpA_o, 0);
    ev = (exp_q.size() > 0) && exp_q[0].returned;
    check_eq("resp_valid", RespValid_o, ev);
    if (ev) begin
      check_eq("resp_res", RespRes_o, exp_q[0].res);
      check_eq("resp_status", RespStatus_o, exp_q[0].st);
      check_eq("resp_id", RespId_o, exp_q[0].id);
    end
    check_eq("busy", Busy_o, exp_q.size() != 0);
    check_eq("tag_err", TagErr_o, exp_tagerr);

    Req_i       = ($urandom_range(99) < req_pct);
    OpA_i       = $urandom;
    Rnd_i       = RND_WIDTH'($urandom);
    Id_i        = ID_WIDTH'($urandom);
    UnitReady_i = ($urandom_range(99) < 85);
    RespReady_i = ($urandom_range(99) < rdy_pct);
    UnitValid_i = 1'b0; UnitTag_i = '0; UnitRes_i = '0; UnitStatus_i = '0;
    ri = -1;
    if ($urandom_range(99) < ret_pct) begin
      int elig[$];
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].age >= 1) elig.push_back(i);
      if (elig.size() > 0) begin
        ri = elig[$urandom_range(elig.size() - 1)];
        UnitValid_i  = 1'b1;
        UnitTag_i    = TAG_WIDTH'(pend[ri].tag);
        UnitRes_i    = pend[ri].res;
        UnitStatus_i = pend[ri].st;
      end
    end
    #1;
    g = Req_i && UnitReady_i && (exp_q.size() < NUM_SLOTS);
    check_eq("gnt", Gnt_o, g);
    r = ev && RespReady_i;

    @(posedge clk);
    for (int i = 0; i < pend.size(); i++) pend[i].age++;
    if (ri >= 0) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].tag == pend[ri].tag) exp_q[i].returned = 1'b1;
      pend.delete(ri);
    end
    if (r) void'(exp_q.pop_front());
    exp_en = g;
    if (g) begin
      iss_opa = OpA_i;
      iss_rnd = Rnd_i;
      iss_tag = issued % NUM_SLOTS;
      issued++;
      exp_q.push_back('{Id_i, fres(OpA_i), fstat(OpA_i), iss_tag, 1'b0});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    Req_i = 0; OpA_i = '0; Rnd_i = '0; Id_i = '0; RespReady_i = 0;
    UnitReady_i = 0; UnitValid_i = 0; UnitTag_i = '0; UnitRes_i = '0; UnitStatus_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_unit_en", UnitEn_o, 0);
    check_eq("rst_resp_valid", RespValid_o, 0);
    check_eq("rst_resp_res", RespRes_o, 0);
    check_eq("rst_unit_opa", UnitOpA_o, 0);
    check_eq("rst_unit_tag", UnitTag_o, 0);
    check_eq("rst_busy", Busy_o, 0);
    check_eq("rst_tag_err", TagErr_o, 0);
    rst = 1'b0;

    repeat (150) cycle(60, 80, 50);   // mixed traffic, any return order
    repeat (40)  cycle(100, 0, 60);   // core stalls: slots fill, grant drops, responses hold
    repeat (150) cycle(70, 90, 70);   // streaming with tag wrap
    repeat (60)  cycle(90, 30, 20);   // slow unit and bursty core

    n = 0;
    while ((exp_q.size() != 0 || exp_en) && n < 300) begin
      cycle(0, 100, 100);
      n++;
    end
    check_eq("drain_timeout", n < 300, 1);
    cycle(0, 100, 100);

    // Stray result to a free slot: never a response; flagged only with tag checking.
    @(negedge clk);
    Req_i = 0; RespReady_i = 0; UnitReady_i = 0;
    UnitValid_i = 1'b1; UnitTag_i = 2'd2; UnitRes_i = 32'hdead_beef; UnitStatus_i = 8'h5a;
    @(posedge clk);
`ifdef FP_DISPATCH_TAGCHK_EN
    exp_tagerr = 1'b1;
`endif
    repeat (5)   cycle(0, 100, 0);
    repeat (100) cycle(60, 70, 60);  // later allocations must not see the stray result

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
